div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
//
// PURPOSE
//  Upstream feeder and result collector for the iterative divider. Queues operand pairs
//  from a valid/ready source and issues them one at a time via a start/done handshake.
//  Captures quotient/remainder and presents them downstream on a valid/ready port.
//  Short-circuits divide-by-zero and flags a divider that never answers (timeout).
//
// PARAMETERS
//  SIZE     32  operand/result width, must match the divider's SIZE
//  DEPTH    4   operand FIFO entries, power of two, >= 2
//  TIMEOUT  64  max cycles in WAIT before abort, must exceed divider worst-case latency
//
// PORTS
//  clk              in   1     system clock, rising edge
//  rst_n            in   1     asynchronous active-low reset
//  in_valid         in   1     operand pair offered
//  in_ready         out  1     FIFO can accept (= !full)
//  in_numerador     in   SIZE  dividend
//  in_denominador   in   SIZE  divisor
//  div_start        out  1     one-cycle start pulse to divider
//  div_numerador    out  SIZE  dividend to divider, registered
//  div_denominador  out  SIZE  divisor to divider, registered
//  div_cociente     in   SIZE  divider quotient
//  div_resto        in   SIZE  divider remainder
//  div_done         in   1     divider result valid
//  out_valid        out  1     result available
//  out_ready        in   1     downstream accepts result
//  out_cociente     out  SIZE  quotient
//  out_resto        out  SIZE  remainder
//  out_div0         out  1     result came from a zero divisor
//  out_timeout      out  1     divider did not answer within TIMEOUT cycles
//
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, except in_ready=1; FIFO empty, FSM=IDLE, timer 0.
//  - FIFO: push on in_valid&&in_ready; in_ready registered-free = !full; push when full is impossible.
//    Push and pop in the same cycle allowed at any occupancy; order preserved (FIFO).
//  - FSM states IDLE, ISSUE, WAIT, HOLD:
//    IDLE: if FIFO non-empty, pop head. den!=0 -> load div_numerador/div_denominador, -> ISSUE.
//          den==0 -> out_cociente={SIZE{1}}, out_resto=num, out_div0=1, -> HOLD (no div_start).
//    ISSUE: div_start=1 for exactly this cycle; timer cleared; -> WAIT.
//    WAIT: div_done=1 -> capture div_cociente/div_resto, out_div0=0, out_timeout=0, -> HOLD.
//          Timer increments each cycle; timer==TIMEOUT-1 without done -> out_cociente=0,
//          out_resto=0, out_timeout=1, -> HOLD. Done on that same cycle wins (normal capture).
//    HOLD: out_valid=1; outputs stable while !out_ready; out_valid&&out_ready -> IDLE.
//  - Latency: operand accepted at edge k into empty FIFO, FSM in IDLE -> div_start high in the
//    cycle after edge k+2 (pop at k+1, ISSUE at k+2). One result per operand pair, in order.
//  - div_numerador/div_denominador held constant from ISSUE until the WAIT->HOLD transition.
//  - div_done outside WAIT (IDLE/ISSUE/HOLD, incl. late done after timeout) is ignored.
//  - out_valid is never dropped without out_ready; no new div_start while in HOLD.
//  - Timer width $clog2(TIMEOUT+1); never wraps.
//
// TESTING
//  1. push 100/7; model done 5 cyc after start with 14/2 -> one div_start pulse, out 14/2, div0=0
//  2. push 55/0 -> no div_start; out_cociente=32'hFFFFFFFF, out_resto=55, out_div0=1
//  3. out_ready=0, push 6 pairs back-to-back, DEPTH=4 -> in_ready=0 with 4 queued; release
//     -> 6 results in push order, no loss or duplicate
//  4. out_ready=0 for 10 cycles in HOLD -> outputs bit-stable, no div_start, FIFO still accepts
//  5. div_done held 0 -> out_valid TIMEOUT cycles after div_start, out_timeout=1; late done ignored
//  6. rst_n=0 mid-WAIT -> outputs 0 same cycle, in_ready=1, FIFO empty; stray done after release ignored

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Operand FIFO and issue/collect sequencer for the iterative divider: feeds one operand
// pair at a time via start/done, short-circuits zero divisors and aborts silent dividers.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid, once raised, stays high with stable payload until that edge.
module div_issue_ctrl #(
    parameter int SIZE    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_numerador,
    input  logic [SIZE-1:0] in_denominador,
    output logic            div_start,
    output logic [SIZE-1:0] div_numerador,
    output logic [SIZE-1:0] div_denominador,
    input  logic [SIZE-1:0] div_cociente,
    input  logic [SIZE-1:0] div_resto,
    input  logic            div_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_cociente,
    output logic [SIZE-1:0] out_resto,
    output logic            out_div0,
    output logic            out_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            start_d, div0_d, tmo_d;
    logic [SIZE-1:0] dnum_d, dden_d, quo_d, rem_d;

    logic [SIZE-1:0] mem_num [DEPTH];
    logic [SIZE-1:0] mem_den [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop, empty, full;
    logic [SIZE-1:0] head_num, head_den;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == IDLE) && !empty;
    assign head_num  = mem_num[rd_ptr];
    assign head_den  = mem_den[rd_ptr];
    assign out_valid = (state_q == HOLD);

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_num[wr_ptr] <= in_numerador;
            mem_den[wr_ptr] <= in_denominador;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            div_start       <= 1'b0;
            div_numerador   <= '0;
            div_denominador <= '0;
            out_cociente    <= '0;
            out_resto       <= '0;
            out_div0        <= 1'b0;
            out_timeout     <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            div_start       <= start_d;
            div_numerador   <= dnum_d;
            div_denominador <= dden_d;
            out_cociente    <= quo_d;
            out_resto       <= rem_d;
            out_div0        <= div0_d;
            out_timeout     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start_d = 1'b0;
        dnum_d  = div_numerador;
        dden_d  = div_denominador;
        quo_d   = out_cociente;
        rem_d   = out_resto;
        div0_d  = out_div0;
        tmo_d   = out_timeout;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_den != '0) begin
                        dnum_d  = head_num;
                        dden_d  = head_den;
                        state_d = ISSUE;
                    end else begin
                        quo_d   = '1;
                        rem_d   = head_num;
                        div0_d  = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = HOLD;
                    end
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still counts as a real answer.
                if (div_done) begin
                    quo_d   = div_cociente;
                    rem_d   = div_resto;
                    div0_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = HOLD;
                end else if (timer_q == TMO_LAST) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    div0_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: behavioural divider, expected-result queue
// checked by a negedge monitor, and targeted checks for latency, backpressure and reset.
module tb_div_issue_ctrl;

    localparam int SIZE    = 32;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_numerador, in_denominador;
    logic            div_start;
    logic [SIZE-1:0] div_numerador, div_denominador;
    logic [SIZE-1:0] div_cociente, div_resto;
    logic            div_done;
    logic            out_valid, out_ready;
    logic [SIZE-1:0] out_cociente, out_resto;
    logic            out_div0, out_timeout;

    logic [65:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int valid_rise_cyc = 0;
    int results_seen = 0;
    int acc_edge = 0;
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    bit dm_en = 1'b1;
    int dm_lat = 5;
    int stray_req = 0;
    int stray_ack = 0;

    div_issue_ctrl #(.SIZE(SIZE), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_numerador(in_numerador), .in_denominador(in_denominador),
        .div_start(div_start), .div_numerador(div_numerador), .div_denominador(div_denominador),
        .div_cociente(div_cociente), .div_resto(div_resto), .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cociente(out_cociente), .out_resto(out_resto),
        .out_div0(out_div0), .out_timeout(out_timeout)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural divider ----------------
    initial begin : divider_model
        logic [SIZE-1:0] n, d;
        div_done = 1'b0;
        div_cociente = '0;
        div_resto = '0;
        forever begin
            @(negedge clk);
            if (rst_n && div_start && dm_en) begin
                n = div_numerador;
                d = div_denominador;
                repeat (dm_lat) @(posedge clk);
                #1;
                div_done = 1'b1;
                div_cociente = n / d;
                div_resto = n % d;
                @(posedge clk);
                #1;
                div_done = 1'b0;
            end else if (stray_req != stray_ack) begin
                @(posedge clk);
                #1;
                div_done = 1'b1;
                div_cociente = 32'hDEAD_BEEF;
                div_resto = 32'h1234_5678;
                repeat (2) @(posedge clk);
                #1;
                div_done = 1'b0;
                stray_ack++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_start) begin
                start_cnt++;
                start_cyc = cyc;
                if (prev_start) begin
                    checks++;
                    errors++;
                    $display("FAIL start_pulse_width: got 2+ cycles expected 1");
                end
            end
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            if (out_valid && out_ready) begin
                results_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none",
                             {out_timeout, out_div0, out_cociente, out_resto});
                end else begin
                    chk("result", {out_timeout, out_div0, out_cociente, out_resto},
                        exp_q.pop_front());
                end
            end
            prev_start = div_start;
            prev_valid = out_valid;
        end else begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_res(input logic tmo, input logic d0,
                              input logic [SIZE-1:0] q, input logic [SIZE-1:0] r);
        exp_q.push_back({tmo, d0, q, r});
    endtask

    task automatic push(input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_numerador = n;
        in_denominador = d;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: got in_ready=0 after %0d cycles expected 1", w);
        end
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < limit) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending after %0d cycles expected 0", exp_q.size(), w);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, r0, w;
        logic [67:0] snap;
        bit stable;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_numerador = '0;
        in_denominador = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 66'({div_start, out_valid, out_div0, out_timeout, in_ready}), 66'(5'b00001));
        chk("rst_data", 66'(out_cociente | out_resto | div_numerador | div_denominador), 66'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: plain division, latency and single start pulse
        dm_lat = 5;
        s0 = start_cnt;
        expect_res(1'b0, 1'b0, 32'd14, 32'd2);
        push(32'd100, 32'd7);
        wait_drain(300);
        chk("t1_latency", 66'(start_cyc - acc_edge), 66'd2);
        chk("t1_starts", 66'(start_cnt - s0), 66'd1);

        // 2: zero divisor bypasses the divider
        s0 = start_cnt;
        expect_res(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd55);
        push(32'd55, 32'd0);
        wait_drain(300);
        chk("t2_starts", 66'(start_cnt - s0), 66'd0);

        // 3/4: backpressure, full FIFO, HOLD stability
        dm_lat = 3;
        out_ready = 1'b0;
        r0 = results_seen;
        expect_res(1'b0, 1'b0, 32'd6, 32'd2);
        expect_res(1'b0, 1'b0, 32'd100, 32'd0);
        expect_res(1'b0, 1'b0, 32'd0, 32'd7);
        expect_res(1'b0, 1'b0, 32'd0, 32'd0);
        expect_res(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
        expect_res(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd81);
        push(32'd20, 32'd3);
        push(32'd1000, 32'd10);
        push(32'd7, 32'd9);
        push(32'd0, 32'd5);
        push(32'hFFFF_FFFF, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_full", 66'(in_ready), 66'd0);
        chk("t4_valid", 66'(out_valid), 66'd1);
        s0 = start_cnt;
        snap = {out_cociente, out_resto, out_div0, out_timeout, out_valid, div_start};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_cociente, out_resto, out_div0, out_timeout, out_valid, div_start} !== snap)
                stable = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("t4_stable", 66'(stable), 66'd1);
        chk("t4_nostart", 66'(start_cnt - s0), 66'd0);
        out_ready = 1'b1;
        push(32'd81, 32'd0);
        wait_drain(500);
        chk("t3_count", 66'(results_seen - r0), 66'd6);

        // 5: silent divider times out; late done ignored
        dm_en = 1'b0;
        r0 = results_seen;
        expect_res(1'b1, 1'b0, 32'd0, 32'd0);
        push(32'd9, 32'd3);
        wait_drain(300);
        chk("t5_latency", 66'(valid_rise_cyc - start_cyc), 66'(TIMEOUT));
        stray_req++;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_late_done", 66'(out_valid), 66'd0);
        chk("t5_count", 66'(results_seen - r0), 66'd1);

        // 6: reset in the middle of WAIT
        s0 = start_cnt;
        push(32'd20, 32'd4);
        push(32'd30, 32'd5);
        w = 0;
        while (start_cnt == s0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("t6_started", 66'(start_cnt - s0), 66'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 66'({div_start, out_valid, out_div0, out_timeout, in_ready}), 66'(5'b00001));
        chk("t6_rst_data", 66'(out_cociente | out_resto | div_numerador | div_denominador), 66'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = start_cnt;
        r0 = results_seen;
        stray_req++;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_fifo_empty", 66'(start_cnt - s0), 66'd0);
        chk("t6_stray_done", 66'(results_seen - r0), 66'd0);
        chk("t6_in_ready", 66'(in_ready), 66'd1);

        chk("queue_empty", 66'(exp_q.size()), 66'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
